// File: rtl/tone_player_if.sv
// Request channel into tone_player: pitch code and beat count with valid/ready handshake.
interface tone_player_if;
  logic [3:0] inote;
  logic [3:0] idur;
  logic       ivalid;
  logic       oready;

  modport master (output inote, output idur, output ivalid, input oready);
  modport slave  (input inote, input idur, input ivalid, output oready);
endinterface

// File: rtl/tone_player.sv
// tone_player: accepts note requests, drives the piezo square wave, times beats and the inter-note gap.
// Optional macro TONE_PREFETCH_EN adds a one-entry request holding register.
module tone_player #(
  parameter int BEAT_CYCLES    = 6250000,
  parameter int GAP_CYCLES     = 500000,
  parameter int TONE_DIV_SHIFT = 0
) (
  input  logic         iclk,
  input  logic         irst,
  tone_player_if.slave bus,
  output logic         ospk,
  output logic         obusy,
  output logic         obeat
);

  localparam int BW = $clog2(BEAT_CYCLES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  // Half-period in iclk cycles, round(25e6/f), codes 1..15 = C4..D5.
  function automatic logic [16:0] hp_of(input logic [3:0] n);
    logic [16:0] v;
    case (n)
      4'd1:    v = 17'd95555;
      4'd2:    v = 17'd90194;
      4'd3:    v = 17'd85132;
      4'd4:    v = 17'd80353;
      4'd5:    v = 17'd75843;
      4'd6:    v = 17'd71586;
      4'd7:    v = 17'd67569;
      4'd8:    v = 17'd63776;
      4'd9:    v = 17'd60197;
      4'd10:   v = 17'd56818;
      4'd11:   v = 17'd53630;
      4'd12:   v = 17'd50620;
      4'd13:   v = 17'd47778;
      4'd14:   v = 17'd45096;
      4'd15:   v = 17'd42566;
      default: v = 17'd0;
    endcase
    return v >> TONE_DIV_SHIFT;
  endfunction

  state_t          r_state, w_next;
  logic [16:0]     r_hp, r_tone_cnt;
  logic            r_rest, r_spk;
  logic [BW-1:0]   r_beat_cnt;
  logic [4:0]      r_beats_left;
  logic [GW-1:0]   r_gap_cnt;

  logic            w_ready, w_xfer, w_load;
  logic            w_beat_end, w_last_beat, w_gap_end;
  logic [3:0]      w_ld_note, w_ld_dur;

`ifdef TONE_PREFETCH_EN
  logic            r_hold_vld;
  logic [3:0]      r_hold_note, r_hold_dur;
  logic            w_hold_set, w_hold_take;

  assign w_ready = !irst && !r_hold_vld;
`else
  assign w_ready = !irst && (r_state == S_IDLE);
`endif

  assign bus.oready  = w_ready;
  assign w_xfer      = bus.ivalid && w_ready;
  assign w_beat_end  = (r_state == S_PLAY) && (r_beat_cnt == BEAT_LAST);
  assign w_last_beat = w_beat_end && (r_beats_left == 5'd1);
  assign w_gap_end   = (r_state == S_GAP) && (r_gap_cnt == GAP_LAST);

  always_ff @(posedge iclk) begin
    if (irst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_ld_note = bus.inote;
    w_ld_dur  = bus.idur;
    ospk      = r_spk;
    obusy     = (r_state != S_IDLE);
    obeat     = w_beat_end && !irst;
`ifdef TONE_PREFETCH_EN
    w_hold_set  = 1'b0;
    w_hold_take = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef TONE_PREFETCH_EN
        if (r_hold_vld) begin
          w_load      = 1'b1;
          w_hold_take = 1'b1;
          w_ld_note   = r_hold_note;
          w_ld_dur    = r_hold_dur;
        end else if (w_xfer) begin
          w_load = 1'b1;
        end
`else
        if (w_xfer) w_load = 1'b1;
`endif
      end
      S_PLAY: begin
        if (w_last_beat) w_next = S_GAP;
`ifdef TONE_PREFETCH_EN
        if (w_xfer) w_hold_set = 1'b1;
`endif
      end
      S_GAP: begin
`ifdef TONE_PREFETCH_EN
        // A queued request skips IDLE so obusy never drops between notes.
        if (w_gap_end) begin
          if (r_hold_vld) begin
            w_load      = 1'b1;
            w_hold_take = 1'b1;
            w_ld_note   = r_hold_note;
            w_ld_dur    = r_hold_dur;
          end else if (w_xfer) begin
            w_load = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end else if (w_xfer) begin
          w_hold_set = 1'b1;
        end
`else
        if (w_gap_end) w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
    if (w_load) w_next = S_PLAY;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_hp         <= '0;
      r_rest       <= 1'b1;
      r_tone_cnt   <= '0;
      r_beat_cnt   <= '0;
      r_beats_left <= '0;
      r_gap_cnt    <= '0;
      r_spk        <= 1'b0;
    end else if (w_load) begin
      r_hp         <= hp_of(w_ld_note);
      r_rest       <= (w_ld_note == 4'd0);
      r_beats_left <= {(w_ld_dur == 4'd0), w_ld_dur};
      r_tone_cnt   <= '0;
      r_beat_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_spk        <= 1'b0;
    end else begin
      case (r_state)
        S_PLAY: begin
          if (!r_rest) begin
            if (r_tone_cnt == r_hp - 17'd1) begin
              r_tone_cnt <= '0;
              r_spk      <= ~r_spk;
            end else begin
              r_tone_cnt <= r_tone_cnt + 17'd1;
            end
          end
          if (w_beat_end) begin
            r_beat_cnt   <= '0;
            r_beats_left <= r_beats_left - 5'd1;
          end else begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
          end
          // Silence is immediate on entering GAP, even mid half-period.
          if (w_last_beat) begin
            r_spk      <= 1'b0;
            r_tone_cnt <= '0;
            r_gap_cnt  <= '0;
          end
        end
        S_GAP:   r_gap_cnt <= r_gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end

`ifdef TONE_PREFETCH_EN
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_hold_vld  <= 1'b0;
      r_hold_note <= '0;
      r_hold_dur  <= '0;
    end else if (w_hold_set) begin
      r_hold_vld  <= 1'b1;
      r_hold_note <= bus.inote;
      r_hold_dur  <= bus.idur;
    end else if (w_hold_take) begin
      r_hold_vld  <= 1'b0;
    end
  end
`endif

endmodule
